block_stream_gen: RTL and testbench

Character-stream generator that drives the `BlockChecker` input side. It accepts keyword tokens over a valid/ready handshake and serializes them into one ASCII character per clock on `out_char`. The tokens are `begin`, `end`, a filler word, or a space. Optionally it also tracks begin/end nesting and presents the expected checker verdict, so self-checking benches and the on-board demo share one stimulus source.

---
 rtl/block_stream_gen.sv | 223 ++++++++++++++++++++++
 tb/tb_block_stream_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/block_stream_gen.sv
// block_stream_gen: turns begin/end/filler/space tokens into one ASCII
// character per clock for the BlockChecker input side.
// Optional feature macro: BSG_EXPECT_EN adds a begin/end nesting model that
// drives exp_result with the verdict the checker is expected to give.
module block_stream_gen #(
  parameter int DEPTH_W    = 8,
  parameter int AUTO_SPACE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tok_valid,
  output logic       tok_ready,
  input  logic [1:0] tok_type,
  input  logic [2:0] tok_len,
  input  logic       tok_upper,
  output logic [7:0] out_char,
  output logic       out_valid,
  output logic       busy
`ifdef BSG_EXPECT_EN
  ,
  output logic       exp_result
`endif
);

  localparam logic [1:0] TOK_SPACE  = 2'd0;
  localparam logic [1:0] TOK_BEGIN  = 2'd1;
  localparam logic [1:0] TOK_END    = 2'd2;
  localparam logic [1:0] TOK_FILLER = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_SPC  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] type_q, type_d;
  logic [2:0] len_q, len_d;
  logic       upper_q, upper_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] char_q, char_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       last_char;
  logic       is_word;

  // Index of the final character of a token; a zero filler length means one letter.
  function automatic logic [2:0] last_idx(input logic [1:0] t, input logic [2:0] l);
    logic [2:0] r;
    r = 3'd0;
    case (t)
      TOK_BEGIN:  r = 3'd4;
      TOK_END:    r = 3'd2;
      TOK_FILLER: r = (l == 3'd0) ? 3'd0 : l - 3'd1;
      default:    r = 3'd0;
    endcase
    return r;
  endfunction

  // Character of token t at position i; case folding touches letters only.
  function automatic logic [7:0] char_at(input logic [1:0] t, input logic [2:0] i,
                                         input logic up);
    logic [7:0] c;
    logic       letter;
    c      = 8'h20;
    letter = 1'b1;
    case (t)
      TOK_BEGIN: begin
        case (i)
          3'd0:    c = 8'h62;
          3'd1:    c = 8'h65;
          3'd2:    c = 8'h67;
          3'd3:    c = 8'h69;
          default: c = 8'h6E;
        endcase
      end
      TOK_END: begin
        case (i)
          3'd0:    c = 8'h65;
          3'd1:    c = 8'h6E;
          default: c = 8'h64;
        endcase
      end
      TOK_FILLER: c = 8'h61 + {5'd0, i};
      default: begin
        c      = 8'h20;
        letter = 1'b0;
      end
    endcase
    if (up && letter) begin
      c = c - 8'h20;
    end
    return c;
  endfunction

  assign last_char = (idx_q == last_idx(type_q, len_q));
  assign is_word   = (type_q != TOK_SPACE);
  assign tok_ready = (state_q == ST_IDLE);
  assign out_char  = char_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;

  // Next-state, token latch and character index; outputs are derived from the next state.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    len_d   = len_q;
    upper_d = upper_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (tok_valid) begin
          state_d = ST_EMIT;
          type_d  = tok_type;
          len_d   = tok_len;
          upper_d = tok_upper;
          idx_d   = 3'd0;
        end
      end
      ST_EMIT: begin
        if (last_char) begin
          if (is_word && (AUTO_SPACE != 0)) begin
            state_d = ST_SPC;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      ST_SPC: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    char_d  = 8'h00;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    case (state_d)
      ST_EMIT: begin
        char_d  = char_at(type_d, idx_d, upper_d);
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
      ST_SPC: begin
        char_d  = 8'h20;
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
      default: begin
        char_d  = 8'h00;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, latched token and registered outputs; reset abandons any token in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      type_q  <= 2'd0;
      len_q   <= 3'd0;
      upper_q <= 1'b0;
      idx_q   <= 3'd0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      len_q   <= len_d;
      upper_q <= upper_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

`ifdef BSG_EXPECT_EN
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               err_q, err_d;
  logic               exp_q, exp_d;
  logic               word_done;

  assign word_done  = (state_q == ST_EMIT) && last_char;
  assign exp_result = exp_q;

  // Nesting model: updates on the cycle a BEGIN/END shows its last letter.
  always_comb begin
    depth_d = depth_q;
    err_d   = err_q;
    if (word_done && (type_q == TOK_BEGIN)) begin
      if (&depth_q) begin
        err_d = 1'b1;
      end else begin
        depth_d = depth_q + 1'b1;
      end
    end else if (word_done && (type_q == TOK_END)) begin
      if (depth_q != '0) begin
        depth_d = depth_q - 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    exp_d = (depth_d == '0) && !err_d;
  end

  // Depth, sticky error and the registered verdict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth_q <= '0;
      err_q   <= 1'b0;
      exp_q   <= 1'b1;
    end else begin
      depth_q <= depth_d;
      err_q   <= err_d;
      exp_q   <= exp_d;
    end
  end
`endif

endmodule

// File: tb/tb_block_stream_gen.sv
// Directed bench for block_stream_gen with hand-computed character streams.
module tb_block_stream_gen;

  logic       clk;
  logic       reset;
  logic       tok_valid;
  logic       tok_ready;
  logic [1:0] tok_type;
  logic [2:0] tok_len;
  logic       tok_upper;
  logic [7:0] out_char;
  logic       out_valid;
  logic       busy;
`ifdef BSG_EXPECT_EN
  logic       exp_result;
`endif

  int n_total = 0;
  int n_bad   = 0;

  block_stream_gen #(.DEPTH_W(8), .AUTO_SPACE(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .tok_type  (tok_type),
    .tok_len   (tok_len),
    .tok_upper (tok_upper),
    .out_char  (out_char),
    .out_valid (out_valid),
    .busy      (busy)
`ifdef BSG_EXPECT_EN
    ,
    .exp_result(exp_result)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_idle_char"}, {24'd0, out_char}, 32'h00);
    check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_idle_ready"}, {31'd0, tok_ready}, 32'd1);
  endtask

  // Present one token, wait (bounded) for acceptance, then compare n chars and the idle gap.
  task automatic do_tok(input string tag, input logic [1:0] t, input logic [2:0] l,
                        input logic u, input logic [63:0] exp_str, input int n);
    int waited;
    logic [7:0] e;
    @(negedge clk);
    tok_valid = 1'b1;
    tok_type  = t;
    tok_len   = l;
    tok_upper = u;
    waited = 0;
    while (!tok_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    tok_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      e = exp_str[(n-1-i)*8 +: 8];
      check($sformatf("%s_char%0d", tag, i), {24'd0, out_char}, {24'd0, e});
      check($sformatf("%s_valid%0d", tag, i), {31'd0, out_valid}, 32'd1);
      check($sformatf("%s_busy%0d", tag, i), {31'd0, busy}, 32'd1);
      if (i != n - 1) @(negedge clk);
    end
    @(negedge clk);
    check_idle(tag);
    $display("token %s type=%0d len=%0d upper=%0d chars=%0d", tag, t, l, u, n);
  endtask

  initial begin
    reset     = 1'b0;
    tok_valid = 1'b0;
    tok_type  = 2'd0;
    tok_len   = 3'd0;
    tok_upper = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("rst");
`ifdef BSG_EXPECT_EN
    check("rst_exp", {31'd0, exp_result}, 32'd1);
`endif
    reset = 1'b1;

    // BEGIN lowercase with appended space
    do_tok("begin", 2'd1, 3'd0, 1'b0, 64'h626567696E20, 6);

    // FILLER length 0, with a second request held high during its emission
    @(negedge clk);
    tok_valid = 1'b1;
    tok_type  = 2'd3;
    tok_len   = 3'd0;
    tok_upper = 1'b0;
    @(negedge clk);
    check("fill0_char0", {24'd0, out_char}, 32'h61);
    tok_len   = 3'd7;
    tok_upper = 1'b1;
    @(negedge clk);
    check("fill0_spc", {24'd0, out_char}, 32'h20);
    check("fill0_held_ready", {31'd0, tok_ready}, 32'd0);
    @(negedge clk);
    check_idle("fill0");
    @(negedge clk);
    tok_valid = 1'b0;
    check("fill7_char0", {24'd0, out_char}, 32'h41);
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("fill7_char%0d", i), {24'd0, out_char}, 32'h41 + i);
      check($sformatf("fill7_valid%0d", i), {31'd0, out_valid}, 32'd1);
    end
    @(negedge clk);
    check("fill7_spc", {24'd0, out_char}, 32'h20);
    @(negedge clk);
    check_idle("fill7");
    $display("token held filler len0 then len7 upper");

    // SPACE: one character, no appended space, busy exactly one cycle
    do_tok("space", 2'd0, 3'd0, 1'b1, 64'h20, 1);

    // Reset in the middle of BEGIN (third character)
    @(negedge clk);
    tok_valid = 1'b1;
    tok_type  = 2'd1;
    tok_upper = 1'b0;
    @(negedge clk);
    tok_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_char2", {24'd0, out_char}, 32'h67);
    #2 reset = 1'b0;
    #1;
    check_idle("midrst");
`ifdef BSG_EXPECT_EN
    check("midrst_exp", {31'd0, exp_result}, 32'd1);
`endif
    $display("token begin abandoned by reset");
    @(negedge clk);
    reset = 1'b1;
    do_tok("end", 2'd2, 3'd0, 1'b0, 64'h656E6420, 4);

`ifdef BSG_EXPECT_EN
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("exp_reset", {31'd0, exp_result}, 32'd1);
    do_tok("x_b1", 2'd1, 3'd0, 1'b0, 64'h626567696E20, 6);
    check("exp_b1", {31'd0, exp_result}, 32'd0);
    do_tok("x_b2", 2'd1, 3'd0, 1'b1, 64'h424547494E20, 6);
    check("exp_b2", {31'd0, exp_result}, 32'd0);
    do_tok("x_e1", 2'd2, 3'd0, 1'b0, 64'h656E6420, 4);
    check("exp_e1", {31'd0, exp_result}, 32'd0);
    do_tok("x_e2", 2'd2, 3'd0, 1'b0, 64'h656E6420, 4);
    check("exp_e2", {31'd0, exp_result}, 32'd1);
    do_tok("x_e3", 2'd2, 3'd0, 1'b0, 64'h656E6420, 4);
    check("exp_e3", {31'd0, exp_result}, 32'd0);
    do_tok("x_b3", 2'd1, 3'd0, 1'b0, 64'h626567696E20, 6);
    do_tok("x_e4", 2'd2, 3'd0, 1'b0, 64'h656E6420, 4);
    check("exp_sticky", {31'd0, exp_result}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("exp_cleared", {31'd0, exp_result}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
